// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry add/subtract unit. Each stage resolves one CHUNK-bit slice of the
// result; the carry is registered between stages. Valid/ready handshake on both sides.
module pipelined_ripple_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / CHUNK;
    // Operand registers feed stages 1..STAGES-1; keep at least one entry for STAGES==1.
    localparam int unsigned OPS = (STAGES > 1) ? STAGES - 1 : 1;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  opa_q [OPS];
    logic [WIDTH-1:0]  opa_d [OPS];
    logic [WIDTH-1:0]  opb_q [OPS];
    logic [WIDTH-1:0]  opb_d [OPS];
    logic              ovf_q, ovf_d;

    logic              adv;
    logic [WIDTH-1:0]  b_eff;
    logic              carry_in0;
    logic [CHUNK+1:0]  res [STAGES];

    // Returns {carry into top bit, carry out, sum} of a CHUNK-bit full-adder ripple.
    function automatic logic [CHUNK+1:0] ripple(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
        logic [CHUNK:0]   c;
        logic [CHUNK-1:0] sm;
        c[0] = ci;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            sm[i]  = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (y[i] & c[i]) | (c[i] & x[i]);
        end
        return {c[CHUNK-1], c[CHUNK], sm};
    endfunction

    always_comb begin
        adv       = out_ready | ~valid_q[STAGES-1];
        b_eff     = sub ? ~b : b;
        carry_in0 = sub | cin;

        valid_d[0] = in_valid;
        res[0]     = ripple(a[CHUNK-1:0], b_eff[CHUNK-1:0], carry_in0);
        sum_d[0]   = '0;
        sum_d[0][CHUNK-1:0] = res[0][CHUNK-1:0];
        carry_d[0] = res[0][CHUNK];

        // Operands are shifted down so every stage reads its slice from the low bits.
        opa_d[0] = a >> CHUNK;
        opb_d[0] = b_eff >> CHUNK;
        for (int unsigned k = 1; k < OPS; k++) begin
            opa_d[k] = opa_q[k-1] >> CHUNK;
            opb_d[k] = opb_q[k-1] >> CHUNK;
        end

        for (int unsigned k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            res[k]     = ripple(opa_q[k-1][CHUNK-1:0], opb_q[k-1][CHUNK-1:0], carry_q[k-1]);
            sum_d[k]   = sum_q[k-1];
            sum_d[k][k*CHUNK +: CHUNK] = res[k][CHUNK-1:0];
            carry_d[k] = res[k][CHUNK];
        end

        ovf_d = res[STAGES-1][CHUNK+1] ^ res[STAGES-1][CHUNK];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
            end
            for (int unsigned k = 0; k < OPS; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else if (adv) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                sum_q[k] <= sum_d[k];
            end
            for (int unsigned k = 0; k < OPS; k++) begin
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
            end
        end
    end

    assign in_ready  = adv;
    assign out_valid = valid_q[STAGES-1];
    assign s         = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Scoreboard bench: main instance WIDTH=16/CHUNK=4 with directed and random traffic, plus
// WIDTH=8/CHUNK=8 and WIDTH=32/CHUNK=4 instances swept against a reference model.
module tb_pipelined_ripple_adder;

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk, rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic        iv16, ir16, ci16, sb16, ov16, or16, co16, of16;
    logic [15:0] a16, b16, s16;
    logic        iv8, ir8, ci8, sb8, ov8, or8, co8, of8;
    logic [7:0]  a8, b8, s8;
    logic        iv32, ir32, ci32, sb32, ov32, or32, co32, of32;
    logic [31:0] a32, b32, s32;

    exp_t cur16, cur8, cur32;
    exp_t q16[$], q8[$], q32[$];
    logic chk_lat16 = 1'b0;
    int   pops16 = 0;
    logic hold16 = 1'b0;
    logic [17:0] held16;

    pipelined_ripple_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .cin(ci16), .sub(sb16), .out_valid(ov16), .out_ready(or16), .s(s16), .cout(co16),
        .ovf(of16)
    );
    pipelined_ripple_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(ci8), .sub(sb8), .out_valid(ov8), .out_ready(or8), .s(s8), .cout(co8),
        .ovf(of8)
    );
    pipelined_ripple_adder #(.WIDTH(32), .CHUNK(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .cin(ci32), .sub(sb32), .out_valid(ov32), .out_ready(or32), .s(s32), .cout(co32),
        .ovf(of32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: plain wide arithmetic; overflow from operand/result sign bits.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sb);
        exp_t        e;
        logic [32:0] mask, bp, sum;
        mask   = (33'd1 << w) - 33'd1;
        bp     = (sb ? ~{1'b0, b} : {1'b0, b}) & mask;
        sum    = ({1'b0, a} & mask) + bp + {32'd0, (sb ? 1'b1 : ci)};
        e.s    = sum[31:0] & mask[31:0];
        e.cout = sum[w];
        e.ovf  = (a[w-1] == bp[w-1]) && (sum[w-1] != a[w-1]);
        e.cyc  = 0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] s, input logic co, input logic of);
        exp_t e;
        e.s = s; e.cout = co; e.ovf = of; e.cyc = 0;
        return e;
    endfunction

    // Main-lane monitor: push on accept, pop and compare on output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold16 = 1'b0;
        end else begin
            if (iv16 && ir16) begin
                e = cur16; e.cyc = cyc; q16.push_back(e);
            end
            if (hold16) begin
                check_eq("hold_valid16", ov16, 1);
                check_eq("hold_data16", {co16, of16, s16}, held16);
            end
            if (ov16 && or16) begin
                check_eq("unexpected_out16", q16.size() > 0, 1);
                if (q16.size() > 0) begin
                    e = q16.pop_front();
                    pops16++;
                    check_eq("s16", s16, e.s);
                    check_eq("cout16", co16, e.cout);
                    check_eq("ovf16", of16, e.ovf);
                    if (chk_lat16) check_eq("latency16", cyc - e.cyc, 4);
                end
            end
            hold16 = ov16 && !or16;
            held16 = {co16, of16, s16};
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (iv8 && ir8) begin e = cur8; e.cyc = cyc; q8.push_back(e); end
            if (ov8 && or8) begin
                check_eq("unexpected_out8", q8.size() > 0, 1);
                if (q8.size() > 0) begin
                    e = q8.pop_front();
                    check_eq("s8", s8, e.s);
                    check_eq("cout8", co8, e.cout);
                    check_eq("ovf8", of8, e.ovf);
                    check_eq("latency8", cyc - e.cyc, 1);
                end
            end
            if (iv32 && ir32) begin e = cur32; e.cyc = cyc; q32.push_back(e); end
            if (ov32 && or32) begin
                check_eq("unexpected_out32", q32.size() > 0, 1);
                if (q32.size() > 0) begin
                    e = q32.pop_front();
                    check_eq("s32", s32, e.s);
                    check_eq("cout32", co32, e.cout);
                    check_eq("ovf32", of32, e.ovf);
                    check_eq("latency32", cyc - e.cyc, 8);
                end
            end
        end
    end

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic sb, input exp_t e);
        int   n;
        logic acc;
        a16 = a; b16 = b; ci16 = ci; sb16 = sb; cur16 = e; iv16 = 1'b1; n = 0;
        do begin
            @(negedge clk);
            acc = ir16;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) check_eq("accept_timeout16", acc, 1);
        iv16 = 1'b0;
    endtask

    task automatic idle(input int n);
        iv16 = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((q16.size() + q8.size() + q32.size()) != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("drain_empty", q16.size() + q8.size() + q32.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic done;
        int   p0;
        rst_n = 1'b1;
        {iv16, ci16, sb16, iv8, ci8, sb8, iv32, ci32, sb32} = '0;
        a16 = '0; b16 = '0; a8 = '0; b8 = '0; a32 = '0; b32 = '0;
        or16 = 1'b1; or8 = 1'b1; or32 = 1'b1;
        cur16 = mk(0, 0, 0); cur8 = mk(0, 0, 0); cur32 = mk(0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", ov16, 0);
        check_eq("rst_s", s16, 0);
        check_eq("rst_cout", co16, 0);
        check_eq("rst_ovf", of16, 0);
        check_eq("rst_in_ready", ir16, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed cases with an unstalled pipeline: values and 4-cycle latency.
        chk_lat16 = 1'b1;
        send16(16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(32'h0000, 1'b1, 1'b0));
        send16(16'h0005, 16'h0007, 1'b0, 1'b1, mk(32'hFFFE, 1'b0, 1'b0));
        send16(16'h8000, 16'h0001, 1'b1, 1'b1, mk(32'h7FFF, 1'b1, 1'b1));
        send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(32'h8000, 1'b0, 1'b1));
        idle(8);
        chk_lat16 = 1'b0;
        check_eq("directed_pops", pops16, 4);

        // Reset mid-stream with results stalled at the output.
        or16 = 1'b0;
        for (int i = 0; i < 3; i++) send16(16'(i + 1), 16'h0010, 1'b0, 1'b0,
                                           mk(32'(i + 17), 1'b0, 1'b0));
        idle(2);
        check_eq("pre_rst_valid", ov16, 1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", ov16, 0);
        check_eq("async_rst_s", s16, 0);
        check_eq("async_rst_in_ready", ir16, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q16.delete();
        or16 = 1'b1;
        idle(8);
        check_eq("post_rst_no_stale", ov16, 0);

        // Backpressure: 8 back-to-back ops, output stalled for three cycles.
        p0 = pops16;
        fork
            for (int i = 0; i < 8; i++)
                send16(16'(i * 16'h1111), 16'h0123, 1'(i & 1), 1'b0,
                       model(16, 32'(i * 16'h1111), 32'h0123, 1'(i & 1), 1'b0));
            begin
                repeat (5) @(posedge clk);
                #1 or16 = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_eq("stall_in_ready", ir16, 0);
                    @(posedge clk);
                    #1;
                end
                or16 = 1'b1;
            end
        join
        drain();
        check_eq("bp_count", pops16 - p0, 8);

        // Random traffic with random gaps and random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [15:0] ra, rb;
                    logic        rc, rs;
                    ra = 16'($urandom); rb = 16'($urandom);
                    rc = 1'($urandom); rs = 1'($urandom);
                    if ($urandom_range(0, 2) == 0) idle(1);
                    send16(ra, rb, rc, rs, model(16, {16'd0, ra}, {16'd0, rb}, rc, rs));
                end
                done = 1'b1;
            end
            while (!done) begin
                @(posedge clk);
                #1 or16 = ($urandom_range(0, 3) != 0);
            end
        join
        or16 = 1'b1;
        drain();

        // Parameter sweep lanes, always ready downstream so latency stays fixed.
        for (int i = 0; i < 1000; i++) begin
            iv8  = ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); sb8 = 1'($urandom);
            cur8 = model(8, {24'd0, a8}, {24'd0, b8}, ci8, sb8);
            iv32 = ($urandom_range(0, 3) != 0);
            a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom); sb32 = 1'($urandom);
            cur32 = model(32, a32, b32, ci32, sb32);
            @(posedge clk);
            #1;
        end
        iv8 = 1'b0;
        iv32 = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
